fp_norm_pipe: RTL and testbench

Parametrised, pipelined post-divide/post-multiply mantissa normalizer for the floating-point module. It left-justifies a raw mantissa, drops the hidden bit and decrements the biased exponent by the shift amount. It also detects zero and exponent underflow, and carries an opaque tag for the issuing operation. It sits between the mantissa datapath of the divide/multiply units and the rounding/packing stage. It uses a two-stage valid/ready pipeline with full back-pressure at one result per cycle.

---
 rtl/fp_norm_pkg.sv | 15 +
 rtl/leading_zero_count.sv | 23 ++
 rtl/fp_norm_pipe.sv | 123 ++++++++++++
 tb/tb_fp_norm_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared definitions for the floating-point normalize path: count widths and
// the result-flag bundle that the rounding/packing stage also consumes.
package fp_norm_pkg;

    // Bits needed to hold a leading-zero count in the range 0..mant_w inclusive.
    function automatic int lz_w(input int mant_w);
        return $clog2(mant_w + 1);
    endfunction

    typedef struct packed {
        logic zero;
        logic uflow;
    } fp_flags_t;

endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; an all-zero input reports W.
module leading_zero_count
    import fp_norm_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0]          i_data,
    output logic [lz_w(W)-1:0]    o_count
);

    localparam int LZ_W = lz_w(W);

    // Scan upward so the most significant set bit is the last one to assign.
    always_comb begin
        o_count = LZ_W'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = LZ_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage valid/ready mantissa normalizer: S1 captures the operand and its
// leading-zero count, S2 shifts, adjusts the exponent and classifies the result.
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANT_W-1:0]   in_mant,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANT_W-2:0]   out_mant,
    output logic [EXP_W-1:0]    out_exp,
    output logic                out_zero,
    output logic                out_uflow,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int LZ_W  = lz_w(MANT_W);
    localparam int CMP_W = EXP_W + 1;

    logic                w_s2Adv;
    logic                w_s1Adv;
    logic                w_inXfer;
    logic [LZ_W-1:0]     w_lz;

    logic                r_s1Valid;
    logic [MANT_W-1:0]   r_s1Mant;
    logic [EXP_W-1:0]    r_s1Exp;
    logic [TAG_W-1:0]    r_s1Tag;
    logic [LZ_W-1:0]     r_s1Lz;

    fp_flags_t           w_flags;
    logic [MANT_W-2:0]   w_resMant;
    logic [EXP_W-1:0]    w_resExp;

    logic                r_s2Valid;
    fp_flags_t           r_s2Flags;
    logic [MANT_W-2:0]   r_s2Mant;
    logic [EXP_W-1:0]    r_s2Exp;
    logic [TAG_W-1:0]    r_s2Tag;

    // in_ready depends on out_ready through a single OR so a full pipe can
    // still take a beat in the same cycle the head result leaves.
    assign w_s2Adv  = ~r_s2Valid | out_ready;
    assign w_s1Adv  = r_s1Valid & w_s2Adv;
    assign in_ready = ~r_s1Valid | w_s2Adv;
    assign w_inXfer = in_valid & in_ready;

    leading_zero_count #(.W(MANT_W)) u_lzc (
        .i_data  (in_mant),
        .o_count (w_lz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Mant  <= '0;
            r_s1Exp   <= '0;
            r_s1Tag   <= '0;
            r_s1Lz    <= '0;
        end else if (w_inXfer) begin
            r_s1Valid <= 1'b1;
            r_s1Mant  <= in_mant;
            r_s1Exp   <= in_exp;
            r_s1Tag   <= in_tag;
            r_s1Lz    <= w_lz;
        end else if (w_s1Adv) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Underflow compare is one bit wider than the exponent so it stays
    // unsigned and exp == lz is caught as underflow rather than a zero exponent.
    always_comb begin
        w_flags   = '0;
        w_resMant = '0;
        w_resExp  = '0;
        if (r_s1Lz == LZ_W'(MANT_W)) begin
            w_flags.zero = 1'b1;
        end else if ({1'b0, r_s1Exp} <= CMP_W'(r_s1Lz)) begin
            w_flags.uflow = 1'b1;
        end else begin
            w_resMant = (MANT_W-1)'(r_s1Mant << r_s1Lz);
            w_resExp  = r_s1Exp - EXP_W'(r_s1Lz);
        end
    end

    // The payload is only rewritten when a real beat moves in, so a stalled
    // result holds steady and a bubble leaves the last result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Flags <= '0;
            r_s2Mant  <= '0;
            r_s2Exp   <= '0;
            r_s2Tag   <= '0;
        end else if (w_s2Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Flags <= w_flags;
                r_s2Mant  <= w_resMant;
                r_s2Exp   <= w_resExp;
                r_s2Tag   <= r_s1Tag;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign out_mant  = r_s2Mant;
    assign out_exp   = r_s2Exp;
    assign out_zero  = r_s2Flags.zero;
    assign out_uflow = r_s2Flags.uflow;
    assign out_tag   = r_s2Tag;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed plus randomized checks of fp_norm_pipe against a shift-until-
// normalized reference model and an in-order scoreboard.
module tb_fp_norm_pipe;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int TAG_W  = 4;

    typedef struct {
        logic [MANT_W-2:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero;
        logic              uflow;
        logic [TAG_W-1:0]  tag;
    } result_t;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [MANT_W-1:0]   in_mant;
    logic [EXP_W-1:0]    in_exp;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [MANT_W-2:0]   out_mant;
    logic [EXP_W-1:0]    out_exp;
    logic                out_zero;
    logic                out_uflow;
    logic [TAG_W-1:0]    out_tag;

    int      nAsserts = 0;
    int      nFails   = 0;
    result_t sbQ[$];

    fp_norm_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Normalize by shifting one place at a time until the hidden bit is set.
    function automatic result_t refModel(input logic [MANT_W-1:0] m,
                                         input logic [EXP_W-1:0] e,
                                         input logic [TAG_W-1:0] t);
        result_t r;
        logic [MANT_W-1:0] s;
        int lz;
        r.mant = '0; r.exp = '0; r.zero = 1'b0; r.uflow = 1'b0; r.tag = t;
        s = m;
        lz = 0;
        if (m == '0) begin
            r.zero = 1'b1;
        end else begin
            while (s[MANT_W-1] == 1'b0) begin
                s = s << 1;
                lz++;
            end
            if (int'(e) <= lz) begin
                r.uflow = 1'b1;
            end else begin
                r.mant = s[MANT_W-2:0];
                r.exp  = EXP_W'(int'(e) - lz);
            end
        end
        return r;
    endfunction

    task automatic checkOutput();
        result_t r;
        if (out_valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkEq("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                r = sbQ[0];
                checkEq("sb_mant",  64'(out_mant),  64'(r.mant));
                checkEq("sb_exp",   64'(out_exp),   64'(r.exp));
                checkEq("sb_zero",  64'(out_zero),  64'(r.zero));
                checkEq("sb_uflow", 64'(out_uflow), 64'(r.uflow));
                checkEq("sb_tag",   64'(out_tag),   64'(r.tag));
                if (out_ready) void'(sbQ.pop_front());
            end
        end
    endtask

    // Called at a falling edge: drive, settle, score, then advance one cycle.
    task automatic applyStimulus(input logic v, input logic [MANT_W-1:0] m,
                                 input logic [EXP_W-1:0] e, input logic [TAG_W-1:0] t,
                                 input logic ordy, output logic accepted);
        in_valid  = v;
        in_mant   = m;
        in_exp    = e;
        in_tag    = t;
        out_ready = ordy;
        #1;
        checkOutput();
        accepted = v && in_ready && !rst;
        if (accepted) sbQ.push_back(refModel(m, e, t));
        @(negedge clk);
    endtask

    task automatic sendDirected(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                                input logic [TAG_W-1:0] t, input logic [MANT_W-2:0] xMant,
                                input logic [EXP_W-1:0] xExp, input logic xZero,
                                input logic xUflow);
        logic acc;
        applyStimulus(1'b1, m, e, t, 1'b1, acc);
        checkEq("dir_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
        #1;
        checkEq("dir_not_early", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
        #1;
        checkEq("dir_valid",  64'(out_valid), 64'd1);
        checkEq("dir_mant",   64'(out_mant),  64'(xMant));
        checkEq("dir_exp",    64'(out_exp),   64'(xExp));
        checkEq("dir_zero",   64'(out_zero),  64'(xZero));
        checkEq("dir_uflow",  64'(out_uflow), 64'(xUflow));
        checkEq("dir_tag",    64'(out_tag),   64'(t));
        applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkEq({tag, "_in_ready"},  64'(in_ready),  64'd1);
        checkEq({tag, "_out_mant"},  64'(out_mant),  64'd0);
        checkEq({tag, "_out_exp"},   64'(out_exp),   64'd0);
        checkEq({tag, "_out_zero"},  64'(out_zero),  64'd0);
        checkEq({tag, "_out_uflow"}, 64'(out_uflow), 64'd0);
        checkEq({tag, "_out_tag"},   64'(out_tag),   64'd0);
    endtask

    initial begin
        logic              acc;
        logic [MANT_W-1:0] bpMant [4];
        int                idx;
        int                cyc;
        logic [MANT_W-1:0] m;
        logic [EXP_W-1:0]  e;

        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_tag = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkResetState("por");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        sendDirected(24'h800000, 8'd127, 4'd3, 23'h0,      8'd127, 1'b0, 1'b0);
        sendDirected(24'h000001, 8'd100, 4'd5, 23'h0,      8'd77,  1'b0, 1'b0);
        sendDirected(24'h400001, 8'd2,   4'd7, 23'h000002, 8'd1,   1'b0, 1'b0);
        sendDirected(24'h400000, 8'd1,   4'd9, 23'h0,      8'd0,   1'b0, 1'b1);
        sendDirected(24'h000000, 8'd50,  4'd1, 23'h0,      8'd0,   1'b1, 1'b0);
        sendDirected(24'h123456, 8'd0,   4'd2, 23'h0,      8'd0,   1'b0, 1'b1);

        $display("[TB] back-pressure");
        bpMant[0] = 24'hC00000; bpMant[1] = 24'h00F000; bpMant[2] = 24'h000003; bpMant[3] = 24'h7FFFFF;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            if (cyc == 2) begin
                in_valid = 1'b1; out_ready = 1'b0;
                #1;
                checkEq("bp_in_ready_low", 64'(in_ready), 64'd0);
            end
            applyStimulus(1'b1, bpMant[idx], 8'd200, 4'(idx + 8), (cyc >= 3), acc);
            if (acc) idx++;
            cyc++;
        end
        checkEq("bp_all_accepted", 64'(idx), 64'd4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
        checkEq("bp_drained", 64'(sbQ.size()), 64'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 24'h0ABCDE, 8'd90, 4'hA, 1'b0, acc);
        applyStimulus(1'b1, 24'h000777, 8'd90, 4'hB, 1'b0, acc);
        rst = 1'b1;
        applyStimulus(1'b1, 24'h111111, 8'd90, 4'hC, 1'b0, acc);
        sbQ.delete();
        #1;
        checkResetState("midrst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            m = MANT_W'($urandom) >> $urandom_range(0, MANT_W);
            e = ($urandom_range(0, 1) == 1) ? EXP_W'($urandom_range(0, 30)) : EXP_W'($urandom);
            applyStimulus(($urandom_range(0, 3) != 0), m, e, TAG_W'($urandom),
                          ($urandom_range(0, 9) < 7), acc);
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
        checkEq("final_drained", 64'(sbQ.size()), 64'd0);
        #1;
        checkEq("final_idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
